keycode_event_queue: RTL and testbench

Converts the 8-bit keycode level driven by the CPU-written keycode PIO register into a queue of discrete key events (press, release, auto-repeat) for the game-logic side (tower placement/menu FSMs). Sits directly downstream of the keycode PIO: its `keycode` input is the PIO's 8-bit output port. Events are buffered in a small FIFO with a valid/ready consumer handshake, so game logic can drain them at its own pace.

---
 rtl/keycode_event_queue_pkg.sv | 26 ++
 rtl/keycode_event_queue_if.sv | 11 +
 rtl/keycode_event_queue_fifo.sv | 58 +++++
 rtl/keycode_event_queue.sv | 116 +++++++++++
 tb/tb_keycode_event_queue.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/keycode_event_queue_pkg.sv
// Shared types and constants for the keycode event queue: event kinds,
// FSM state encoding and the packed event record stored in the FIFO.
package keyevt_pkg;

  localparam logic [1:0] KEVT_RELEASE = 2'b00;
  localparam logic [1:0] KEVT_PRESS   = 2'b01;
  localparam logic [1:0] KEVT_REPEAT  = 2'b10;

  typedef enum logic [0:0] {
    IDLE       = 1'b0,
    PRESS_PEND = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] code;
  } kevt_t;

  function automatic kevt_t mk_evt(input logic [1:0] kind, input logic [7:0] code);
    kevt_t e;
    e.kind = kind;
    e.code = code;
    return e;
  endfunction

endpackage

// File: rtl/keycode_event_queue_if.sv
// Consumer-side event handshake: the queue drives the head event, game
// logic accepts it with evt_ready.
interface keycode_event_queue_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_kind;
  logic [7:0] evt_code;

  modport master (output evt_valid, output evt_kind, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_kind, input evt_code, output evt_ready);
endinterface

// File: rtl/keycode_event_queue_fifo.sv
// Synchronous event FIFO with registered pointers; a push into a full FIFO
// is accepted only when a pop frees the head slot in the same cycle.
module keyevt_fifo
  import keyevt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  kevt_t                  din_i,
  input  logic                   pop_i,
  output kevt_t                  dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   drop_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  kevt_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [AW:0]    cnt_q;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    drop_o  = push_i && !do_push;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/keycode_event_queue.sv
// Turns the PIO keycode level into press/release/repeat events queued for
// game logic.
//   state      | meaning
//   S_IDLE     | compare kc_q against cur, run repeat timer
//   S_PRESS_PEND | release already pushed, push press(cur) next cycle
module keycode_event_queue
  import keyevt_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 6
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               keycode,
  input  logic                     frame_tick,
  input  logic                     clr_ovf,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  keycode_event_queue_if.master    evt
);

  localparam logic [0:0] S_IDLE       = 1'(IDLE);
  localparam logic [0:0] S_PRESS_PEND = 1'(PRESS_PEND);
  localparam logic [7:0] RD8          = 8'(REPEAT_DELAY);
  localparam logic [7:0] RR8          = 8'(REPEAT_RATE);
  localparam bit         REP_EN       = (REPEAT_DELAY != 0);

  logic [7:0] kc_q;
  logic [7:0] cur_q, cur_d;
  logic [0:0] state_q, state_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic       ovf_q, ovf_d;
  logic       push;
  kevt_t      push_evt;
  kevt_t      head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       drop;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rcnt_d   = rcnt_q;
    push     = 1'b0;
    push_evt = '0;
    case (state_q)
      S_IDLE: begin
        if (kc_q != cur_q) begin
          // a key change wins over a repeat landing in the same cycle
          cur_d  = kc_q;
          rcnt_d = '0;
          push   = 1'b1;
          if (cur_q != 8'd0) begin
            push_evt = mk_evt(KEVT_RELEASE, cur_q);
            if (kc_q != 8'd0) state_d = S_PRESS_PEND;
          end else begin
            push_evt = mk_evt(KEVT_PRESS, kc_q);
          end
        end else if (cur_q == 8'd0) begin
          rcnt_d = '0;
        end else if (frame_tick && REP_EN) begin
          if (rcnt_q == RD8 - 8'd1) begin
            push     = 1'b1;
            push_evt = mk_evt(KEVT_REPEAT, cur_q);
            rcnt_d   = RD8 - RR8;
          end else if (rcnt_q != 8'hFF) begin
            rcnt_d = rcnt_q + 8'd1;
          end
        end
      end
      default: begin
        push     = 1'b1;
        push_evt = mk_evt(KEVT_PRESS, cur_q);
        state_d  = S_IDLE;
      end
    endcase
  end

  assign ovf_d = drop | (ovf_q & ~clr_ovf);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kc_q    <= '0;
      cur_q   <= '0;
      state_q <= S_IDLE;
      rcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      kc_q    <= keycode;
      cur_q   <= cur_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      ovf_q   <= ovf_d;
    end
  end

  keyevt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .din_i   (push_evt),
    .pop_i   (evt.evt_ready),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (drop),
    .count_o (fifo_count)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_kind  = head.kind;
  assign evt.evt_code  = head.code;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Directed and randomized bench for keycode_event_queue against an
// event-level reference model (expected event list per key change / tick).
module tb_keycode_event_queue;
  import keyevt_pkg::*;

  localparam int DEPTH = 4;
  localparam int RD    = 3;
  localparam int RR    = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] keycode = 8'd0;
  logic       frame_tick = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [2:0] fifo_count;
  logic       overflow;

  keycode_event_queue_if evt_if ();

  keycode_event_queue #(.DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .keycode    (keycode),
    .frame_tick (frame_tick),
    .clr_ovf    (clr_ovf),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .evt        (evt_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [9:0] mq[$];
  logic       m_ovf = 1'b0;
  logic [7:0] m_cur = 8'd0;
  int         m_held = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void mpush(input logic [1:0] k, input logic [7:0] c);
    if (mq.size() < DEPTH) mq.push_back({k, c});
    else m_ovf = 1'b1;
  endfunction

  function automatic void mkey(input logic [7:0] k);
    if (k != m_cur) begin
      if (m_cur != 8'd0) mpush(KEVT_RELEASE, m_cur);
      if (k != 8'd0) mpush(KEVT_PRESS, k);
      m_cur  = k;
      m_held = 0;
    end
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_count"}, 32'(fifo_count), 32'(mq.size()));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic set_key(input logic [7:0] k);
    @(negedge clk);
    keycode = k;
    mkey(k);
    repeat (4) @(negedge clk);
    chk_state("set_key");
  endtask

  task automatic do_tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    if (m_cur != 8'd0) begin
      m_held++;
      if (m_held >= RD && ((m_held - RD) % RR) == 0) mpush(KEVT_REPEAT, m_cur);
    end
    repeat (2) @(negedge clk);
    chk_state("tick");
  endtask

  task automatic pop_check();
    chk("pop_valid", 32'(evt_if.evt_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("pop_kind", 32'(evt_if.evt_kind), 32'(mq[0][9:8]));
      chk("pop_code", 32'(evt_if.evt_code), 32'(mq[0][7:0]));
    end
    evt_if.evt_ready = 1'b1;
    @(negedge clk);
    evt_if.evt_ready = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
    chk("pop_count", 32'(fifo_count), 32'(mq.size()));
  endtask

  task automatic drain();
    int guard = 0;
    while (mq.size() != 0 && guard < 16) begin
      pop_check();
      guard++;
    end
    chk("drain_empty", 32'(evt_if.evt_valid), 32'd0);
  endtask

  task automatic clear_ovf();
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    m_ovf = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
  endtask

  initial begin
    evt_if.evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("rst_kind", 32'(evt_if.evt_kind), 32'd0);
    chk("rst_code", 32'(evt_if.evt_code), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // press latency: valid only after the second edge
    keycode = 8'h1A;
    mkey(8'h1A);
    @(negedge clk);
    chk("lat_e1_valid", 32'(evt_if.evt_valid), 32'd0);
    @(negedge clk);
    chk("lat_e2_valid", 32'(evt_if.evt_valid), 32'd1);
    chk("lat_e2_kind", 32'(evt_if.evt_kind), 32'(KEVT_PRESS));
    chk("lat_e2_code", 32'(evt_if.evt_code), 32'h1A);
    chk("lat_e2_count", 32'(fifo_count), 32'd1);
    pop_check();

    // release then press on consecutive cycles
    keycode = 8'h2C;
    mkey(8'h2C);
    repeat (2) @(negedge clk);
    chk("chg_e2_count", 32'(fifo_count), 32'd1);
    chk("chg_e2_kind", 32'(evt_if.evt_kind), 32'(KEVT_RELEASE));
    @(negedge clk);
    chk("chg_e3_count", 32'(fifo_count), 32'd2);
    drain();

    // auto-repeat with delay 3, rate 2
    set_key(8'h04);
    drain();
    for (int t = 1; t <= 8; t++) begin
      do_tick();
      repeat (6) @(negedge clk);
      drain();
    end
    set_key(8'h00);
    drain();
    for (int t = 0; t < 3; t++) do_tick();
    chk("no_rep_after_rel", 32'(fifo_count), 32'd0);

    // fill to DEPTH with the consumer stalled
    set_key(8'h11);
    set_key(8'h22);
    set_key(8'h00);
    chk("full_count", 32'(fifo_count), 32'd4);
    // push and pop in the same cycle while full
    @(negedge clk);
    keycode = 8'h33;
    chk("fp_head_code", 32'(evt_if.evt_code), 32'h11);
    @(negedge clk);
    evt_if.evt_ready = 1'b1;
    @(negedge clk);
    evt_if.evt_ready = 1'b0;
    void'(mq.pop_front());
    mkey(8'h33);
    repeat (2) @(negedge clk);
    chk("fp_count", 32'(fifo_count), 32'd4);
    chk("fp_ovf", 32'(overflow), 32'd0);
    // two dropped events
    set_key(8'h44);
    chk("ovf_set", 32'(overflow), 32'd1);
    clear_ovf();
    drain();

    // reset while PRESS_PEND with 3 events queued
    set_key(8'h05);
    @(negedge clk);
    keycode = 8'h10;
    repeat (2) @(negedge clk);
    chk("pend_count", 32'(fifo_count), 32'd3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("mid_rst_kind", 32'(evt_if.evt_kind), 32'd0);
    chk("mid_rst_code", 32'(evt_if.evt_code), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    mq.delete();
    m_ovf  = 1'b0;
    m_cur  = 8'd0;
    m_held = 0;
    repeat (3) @(negedge clk);
    chk("rst_hold_count", 32'(fifo_count), 32'd0);
    reset_n = 1'b1;
    mkey(8'h10);
    @(negedge clk);
    chk("rel_e1_valid", 32'(evt_if.evt_valid), 32'd0);
    @(negedge clk);
    chk("rel_e2_valid", 32'(evt_if.evt_valid), 32'd1);
    drain();

    // randomized mix of key changes, ticks, pops and flag clears
    for (int i = 0; i < 120; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 2)      set_key(8'($urandom_range(0, 3)));
      else if (r <= 5) do_tick();
      else if (r <= 8) pop_check();
      else             clear_ovf();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
